// File: rtl/lifo_arbiter_if.sv
// Request/response bundle between two requester engines and the shared LIFO arbiter.
// master = requester side, slave = arbiter side.
interface lifo_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH + 1);

   // Handshake: reqN_push/reqN_pop are level requests held until reqN_gnt is seen
   // high at a rising edge; the op commits on that edge. A granted pop answers with
   // reqN_rvalid high for exactly the next cycle alongside reqN_dout.
   logic             req0_push;
   logic             req0_pop;
   logic [WIDTH-1:0] req0_din;
   logic             req0_gnt;
   logic             req0_rvalid;
   logic [WIDTH-1:0] req0_dout;

   logic             req1_push;
   logic             req1_pop;
   logic [WIDTH-1:0] req1_din;
   logic             req1_gnt;
   logic             req1_rvalid;
   logic [WIDTH-1:0] req1_dout;

   logic             empty;
   logic             full;
   logic [LW-1:0]    level;

   modport master (
      output req0_push, req0_pop, req0_din, req1_push, req1_pop, req1_din,
      input  req0_gnt, req0_rvalid, req0_dout, req1_gnt, req1_rvalid, req1_dout,
      input  empty, full, level
   );

   modport slave (
      input  req0_push, req0_pop, req0_din, req1_push, req1_pop, req1_din,
      output req0_gnt, req0_rvalid, req0_dout, req1_gnt, req1_rvalid, req1_dout,
      output empty, full, level
   );
endinterface

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter for two requesters sharing one DEPTH x WIDTH LIFO stack.
// Optional macro LIFO_ARB_ERR_EN adds sticky overflow/underflow flags with err_clr.
module lifo_arbiter #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          rstn,
`ifdef LIFO_ARB_ERR_EN
   input  logic          err_clr,
   output logic          err_ovf,
   output logic          err_udf,
`endif
   lifo_arbiter_if.slave bus
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [LW-1:0]    r_level;
   logic             r_last_gnt;
   logic             r_rvalid0;
   logic             r_rvalid1;
   logic [WIDTH-1:0] r_dout0;
   logic [WIDTH-1:0] r_dout1;

   logic             w_sel_push0, w_sel_pop0, w_sel_push1, w_sel_pop1;
   logic             w_full, w_empty;
   logic             w_elig0, w_elig1;
   logic             w_gnt0, w_gnt1;
   logic             w_pop0, w_pop1;
   logic             w_g_push;
   logic [WIDTH-1:0] w_g_din;
   logic [LW-1:0]    w_lvl_m1;
   logic [AW-1:0]    w_wr_idx, w_rd_idx;
   logic [WIDTH-1:0] w_rd_data;

   // Push wins inside a requester; the pop stays pending behind it.
   assign w_sel_push0 = bus.req0_push;
   assign w_sel_pop0  = bus.req0_pop & ~bus.req0_push;
   assign w_sel_push1 = bus.req1_push;
   assign w_sel_pop1  = bus.req1_pop & ~bus.req1_push;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);

   assign w_elig0 = (w_sel_push0 & ~w_full) | (w_sel_pop0 & ~w_empty);
   assign w_elig1 = (w_sel_push1 & ~w_full) | (w_sel_pop1 & ~w_empty);

   // r_last_gnt=1 means requester 1 was served last, so requester 0 wins a tie.
   assign w_gnt0 = rstn & w_elig0 & (~w_elig1 | r_last_gnt);
   assign w_gnt1 = rstn & w_elig1 & (~w_elig0 | ~r_last_gnt);

   assign w_pop0   = w_gnt0 & w_sel_pop0;
   assign w_pop1   = w_gnt1 & w_sel_pop1;
   assign w_g_push = (w_gnt0 & w_sel_push0) | (w_gnt1 & w_sel_push1);
   assign w_g_din  = w_gnt0 ? bus.req0_din : bus.req1_din;

   assign w_lvl_m1  = r_level - LW'(1);
   assign w_wr_idx  = r_level[AW-1:0];
   assign w_rd_idx  = w_lvl_m1[AW-1:0];
   assign w_rd_data = r_mem[w_rd_idx];

   always_ff @(posedge clk) begin
      if (w_g_push) r_mem[w_wr_idx] <= w_g_din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_level    <= '0;
         r_last_gnt <= 1'b1;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
         r_dout0    <= '0;
         r_dout1    <= '0;
      end else begin
         r_rvalid0 <= w_pop0;
         r_rvalid1 <= w_pop1;
         if (w_pop0) r_dout0 <= w_rd_data;
         if (w_pop1) r_dout1 <= w_rd_data;
         if (w_g_push)                r_level <= r_level + LW'(1);
         else if (w_pop0 | w_pop1)    r_level <= w_lvl_m1;
         if (w_gnt0 | w_gnt1)         r_last_gnt <= w_gnt1;
      end
   end

`ifdef LIFO_ARB_ERR_EN
   logic r_err_ovf, r_err_udf;
   logic w_ovf_set, w_udf_set;

   assign w_ovf_set = (w_sel_push0 | w_sel_push1) & w_full;
   assign w_udf_set = (w_sel_pop0 | w_sel_pop1) & w_empty;

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_err_ovf <= 1'b0;
         r_err_udf <= 1'b0;
      end else begin
         if (w_ovf_set)    r_err_ovf <= 1'b1;
         else if (err_clr) r_err_ovf <= 1'b0;
         if (w_udf_set)    r_err_udf <= 1'b1;
         else if (err_clr) r_err_udf <= 1'b0;
      end
   end

   assign err_ovf = r_err_ovf;
   assign err_udf = r_err_udf;
`endif

   assign bus.req0_gnt    = w_gnt0;
   assign bus.req1_gnt    = w_gnt1;
   assign bus.req0_rvalid = r_rvalid0;
   assign bus.req1_rvalid = r_rvalid1;
   assign bus.req0_dout   = r_dout0;
   assign bus.req1_dout   = r_dout1;
   assign bus.empty       = w_empty;
   assign bus.full        = w_full;
   assign bus.level       = r_level;
endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter: reset, LIFO order, full/empty stalls, round-robin, async reset.
module tb_lifo_arbiter;
   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic clk;
   logic rstn;
`ifdef LIFO_ARB_ERR_EN
   logic err_clr;
   logic err_ovf;
   logic err_udf;
`endif

   int n_checks;
   int n_errors;
   logic [WIDTH-1:0] exp_q[$];

   lifo_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   lifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rstn    (rstn),
`ifdef LIFO_ARB_ERR_EN
      .err_clr (err_clr),
      .err_ovf (err_ovf),
      .err_udf (err_udf),
`endif
      .bus     (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic idle_inputs();
      bus.req0_push = 1'b0; bus.req0_pop = 1'b0; bus.req0_din = '0;
      bus.req1_push = 1'b0; bus.req1_pop = 1'b0; bus.req1_din = '0;
`ifdef LIFO_ARB_ERR_EN
      err_clr = 1'b0;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic push0(input logic [WIDTH-1:0] d);
      bus.req0_push = 1'b1;
      bus.req0_din  = d;
      #1 check("push0_gnt", 32'(bus.req0_gnt), 32'd1);
      step();
      bus.req0_push = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      do_reset();
      #1;
      check("rst_level",  32'(bus.level), 32'd0);
      check("rst_empty",  32'(bus.empty), 32'd1);
      check("rst_full",   32'(bus.full), 32'd0);
      check("rst_rvalid0", 32'(bus.req0_rvalid), 32'd0);
      check("rst_rvalid1", 32'(bus.req1_rvalid), 32'd0);
      check("rst_dout1",  32'(bus.req1_dout), 32'd0);
      @(negedge clk);

      // LIFO order: push A1, A2; req1 pops A2 then A1
      push0(8'hA1);
      push0(8'hA2);
      check("t1_level2", 32'(bus.level), 32'd2);
      bus.req1_pop = 1'b1;
      #1 check("t1_gnt1_a", 32'(bus.req1_gnt), 32'd1);
      step();
      check("t1_rvalid_a", 32'(bus.req1_rvalid), 32'd1);
      check("t1_dout_a", 32'(bus.req1_dout), 32'hA2);
      check("t1_level1", 32'(bus.level), 32'd1);
      step();
      check("t1_rvalid_b", 32'(bus.req1_rvalid), 32'd1);
      check("t1_dout_b", 32'(bus.req1_dout), 32'hA1);
      check("t1_empty", 32'(bus.empty), 32'd1);
      check("t1_level0", 32'(bus.level), 32'd0);
      #1 check("t1_gnt1_empty", 32'(bus.req1_gnt), 32'd0);
      step();
      check("t1_rvalid_stall", 32'(bus.req1_rvalid), 32'd0);
      check("t1_dout_hold", 32'(bus.req1_dout), 32'hA1);
      bus.req1_pop = 1'b0;

      // full: 8 pushes, 9th stalls, a pop frees room
      do_reset();
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) push0(WIDTH'(i));
      check("t2_full", 32'(bus.full), 32'd1);
      check("t2_level8", 32'(bus.level), 32'd8);
      bus.req0_push = 1'b1;
      bus.req0_din  = 8'h08;
      for (int i = 0; i < 3; i++) begin
         #1 check("t2_push_stall", 32'(bus.req0_gnt), 32'd0);
         step();
      end
      check("t2_level_hold", 32'(bus.level), 32'd8);
      bus.req1_pop = 1'b1;
      #1 check("t2_pop_gnt", 32'(bus.req1_gnt), 32'd1);
      check("t2_push_gnt_full", 32'(bus.req0_gnt), 32'd0);
      step();
      bus.req1_pop = 1'b0;
      check("t2_dout", 32'(bus.req1_dout), 32'h07);
      check("t2_level7", 32'(bus.level), 32'd7);
      #1 check("t2_push_resume", 32'(bus.req0_gnt), 32'd1);
      step();
      bus.req0_push = 1'b0;
      check("t2_level8b", 32'(bus.level), 32'd8);

      // both push from reset: grants alternate 0,1,0,1...
      do_reset();
      @(negedge clk);
      bus.req0_push = 1'b1;
      bus.req1_push = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         bus.req0_din = WIDTH'(8'h10 + (k + 1) / 2);
         bus.req1_din = WIDTH'(8'h20 + k / 2);
         #1;
         check("t3_gnt0", 32'(bus.req0_gnt), 32'(k % 2 == 0));
         check("t3_gnt1", 32'(bus.req1_gnt), 32'(k % 2 == 1));
         check("t3_level", 32'(bus.level), 32'(k));
         exp_q.push_back((k % 2 == 0) ? WIDTH'(8'h10 + k / 2) : WIDTH'(8'h20 + k / 2));
         step();
      end
      #1 check("t3_full_gnt0", 32'(bus.req0_gnt), 32'd0);
      check("t3_full_gnt1", 32'(bus.req1_gnt), 32'd0);
      bus.req0_push = 1'b0;
      bus.req1_push = 1'b0;
      bus.req0_pop  = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         step();
         check("t3_pop_rvalid", 32'(bus.req0_rvalid), 32'd1);
         check("t3_pop_dout", 32'(bus.req0_dout), 32'(exp_q.pop_back()));
      end
      bus.req0_pop = 1'b0;
      check("t3_empty", 32'(bus.empty), 32'd1);

      // empty: push by 0 and pop by 1 together; pop follows and gets pushed data
      do_reset();
      @(negedge clk);
      bus.req0_push = 1'b1;
      bus.req0_din  = 8'h5C;
      bus.req1_pop  = 1'b1;
      #1 check("t4_gnt0", 32'(bus.req0_gnt), 32'd1);
      check("t4_gnt1", 32'(bus.req1_gnt), 32'd0);
      step();
      bus.req0_push = 1'b0;
      #1 check("t4_gnt1_next", 32'(bus.req1_gnt), 32'd1);
      step();
      bus.req1_pop = 1'b0;
      check("t4_rvalid1", 32'(bus.req1_rvalid), 32'd1);
      check("t4_dout1", 32'(bus.req1_dout), 32'h5C);
      check("t4_rvalid0", 32'(bus.req0_rvalid), 32'd0);

      // async reset mid-cycle with level=3 and a pop pending; req0 served last
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 4; i++) push0(WIDTH'(8'h30 + i));
      bus.req0_pop = 1'b1;
      step();
      bus.req0_pop = 1'b0;
      check("t5_pre_level", 32'(bus.level), 32'd3);
      check("t5_pre_rvalid", 32'(bus.req0_rvalid), 32'd1);
      bus.req1_pop = 1'b1;
      #2 rstn = 1'b0;
      #1;
      check("t5_level", 32'(bus.level), 32'd0);
      check("t5_rvalid0", 32'(bus.req0_rvalid), 32'd0);
      check("t5_dout0", 32'(bus.req0_dout), 32'd0);
      check("t5_gnt1", 32'(bus.req1_gnt), 32'd0);
      check("t5_empty", 32'(bus.empty), 32'd1);
      @(negedge clk);
      bus.req1_pop  = 1'b0;
      bus.req0_push = 1'b1; bus.req0_din = 8'h77;
      bus.req1_push = 1'b1; bus.req1_din = 8'h88;
      rstn = 1'b1;
      #1 check("t5_first_gnt0", 32'(bus.req0_gnt), 32'd1);
      check("t5_first_gnt1", 32'(bus.req1_gnt), 32'd0);
      step();
      check("t5_level1", 32'(bus.level), 32'd1);
      idle_inputs();

`ifdef LIFO_ARB_ERR_EN
      do_reset();
      @(negedge clk);
      check("t6_udf_rst", 32'(err_udf), 32'd0);
      bus.req0_pop = 1'b1;
      step();
      bus.req0_pop = 1'b0;
      check("t6_udf_set", 32'(err_udf), 32'd1);
      step();
      check("t6_udf_sticky", 32'(err_udf), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("t6_udf_clr", 32'(err_udf), 32'd0);
      for (int i = 0; i < DEPTH; i++) push0(WIDTH'(i));
      check("t6_ovf_before", 32'(err_ovf), 32'd0);
      bus.req0_push = 1'b1;
      err_clr = 1'b1;
      step();
      bus.req0_push = 1'b0;
      err_clr = 1'b0;
      check("t6_ovf_set_wins", 32'(err_ovf), 32'd1);
`endif

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
